// File: rtl/cr_lane_adder_pkg.sv
// Shared types and helpers for the correlated-random lane adder.
// Latency: n/a (types and combinational helpers only).
// Backpressure: n/a.
// Contents: prng_t datapath word, width_t lane-width code, cr_cnt_t output
// counter, u32_w_c_t chunk result, cra_state_t FSM state, make_carry_mask.
package cr_lane_adder_pkg;

   localparam int LEN_PRNG   = 256;
   localparam int LEN_MAX_CR = 32;
   localparam int NCHUNK     = LEN_PRNG / 32;

   typedef logic [LEN_PRNG-1:0]   prng_t;
   typedef logic [LEN_MAX_CR-1:0] cr_cnt_t;

   // Thermometer lane-width code: each set bit doubles the lane.
   typedef logic [2:0] width_t;
   localparam width_t W32  = 3'b000;
   localparam width_t W64  = 3'b001;
   localparam width_t W128 = 3'b011;
   localparam width_t W256 = 3'b111;

   // 32-bit chunk sum with its carry out in the MSB.
   typedef struct packed {
      logic        c;
      logic [31:0] s;
   } u32_w_c_t;

   typedef enum logic {CRA_IDLE, CRA_RUN} cra_state_t;

   // Chunk-granular kill mask: bit k set means bit 32k starts a new lane, so
   // the carry from chunk k-1 must not propagate into chunk k.
   function automatic logic [NCHUNK-1:0] make_carry_mask(input width_t w);
      return {~w[0], ~w[1], ~w[0], ~w[2], ~w[0], ~w[1], ~w[0], 1'b1};
   endfunction

   function automatic logic chunk_kill(input width_t w, input logic [2:0] k);
      logic [NCHUNK-1:0] m;
      m = make_carry_mask(w);
      return m[k];
   endfunction

endpackage

// File: rtl/cr_chunk_add32.sv
// 32-bit chunk adder with lane-boundary carry kill and optional subtract.
// Latency: combinational.
// Backpressure: none (pure datapath).
// Ports: a_i/b_i operands, cin_i carry from the chunk below, kill_i lane
// boundary at this chunk, sub_i subtract mode, res_o {carry, sum}.
module cr_chunk_add32
   import cr_lane_adder_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   input  logic        kill_i,
   input  logic        sub_i,
   output u32_w_c_t    res_o
);

   logic [31:0] b_eff;
   logic        cin;

   // Subtraction is a + ~b + 1; the +1 enters at the bottom chunk of every lane.
   assign b_eff = sub_i ? ~b_i : b_i;
   assign cin   = kill_i ? sub_i : cin_i;
   assign res_o = {1'b0, a_i} + {1'b0, b_eff} + {32'b0, cin};

endmodule

// File: rtl/cr_lane_adder.sv
// Two-stage 256-bit SIMD lane adder (32/64/128/256-bit lanes per beat), counted run.
// Latency: 2 cycles accept-to-output; 1 beat/cycle with out_ready_i high.
// Backpressure: valid/ready; each stage advances when empty or its successor advances.
// Ports: clk, rst (async, active-high); start_i/cnt_target_i load a run;
// a_i/b_i/width_i/in_valid_i/in_ready_o input beat; sum_o/out_valid_o/out_ready_i
// output beat; busy_o in RUN; done_o pulse after the final output handshake.
// Build option CR_LANE_SUB_EN adds sub_i (lane-wise a - b when set).
module cr_lane_adder
   import cr_lane_adder_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    start_i,
   input  cr_cnt_t cnt_target_i,
   input  width_t  width_i,
   input  prng_t   a_i,
   input  prng_t   b_i,
`ifdef CR_LANE_SUB_EN
   input  logic    sub_i,
`endif
   input  logic    in_valid_i,
   output logic    in_ready_o,
   output prng_t   sum_o,
   output logic    out_valid_o,
   input  logic    out_ready_i,
   output logic    busy_o,
   output logic    done_o
);

   cra_state_t   state_q;
   cr_cnt_t      target_q, accepted_q, emitted_q;
   logic         done_q;

   logic         s1_vld_q, s1_c3_q, s1_sub_q;
   width_t       s1_w_q;
   logic [127:0] s1_lo_q, s1_a_hi_q, s1_b_hi_q, s1_lo_d;
   logic         s2_vld_q;
   prng_t        sum_q;
   logic [127:0] s2_hi_d;

   logic         sub_in, s1_take, s2_take, in_fire, out_fire, busy;
   logic [4:0]   c1, c2;
   u32_w_c_t     r1 [4];
   u32_w_c_t     r2 [4];
   logic         unused_top_c;

`ifdef CR_LANE_SUB_EN
   assign sub_in = sub_i;
`else
   assign sub_in = 1'b0;
`endif

   assign busy     = (state_q == CRA_RUN);
   assign s2_take  = ~s2_vld_q | out_ready_i;
   assign s1_take  = ~s1_vld_q | s2_take;
   assign in_ready_o = busy & (accepted_q != target_q) & s1_take;
   assign in_fire  = in_valid_i & in_ready_o;
   assign out_fire = s2_vld_q & out_ready_i;

   // Stage 1: chunks 0..3 from the live inputs.
   assign c1[0] = 1'b0;
   for (genvar k = 0; k < 4; k++) begin : g_s1
      cr_chunk_add32 u_add (
         .a_i    (a_i[32*k +: 32]),
         .b_i    (b_i[32*k +: 32]),
         .cin_i  (c1[k]),
         .kill_i (chunk_kill(width_i, 3'(k))),
         .sub_i  (sub_in),
         .res_o  (r1[k])
      );
      assign c1[k+1]           = r1[k].c;
      assign s1_lo_d[32*k +: 32] = r1[k].s;
   end

   // Stage 2: chunks 4..7 from the registered upper halves and chunk-3 carry.
   assign c2[0] = s1_c3_q;
   for (genvar j = 0; j < 4; j++) begin : g_s2
      cr_chunk_add32 u_add (
         .a_i    (s1_a_hi_q[32*j +: 32]),
         .b_i    (s1_b_hi_q[32*j +: 32]),
         .cin_i  (c2[j]),
         .kill_i (chunk_kill(s1_w_q, 3'(j + 4))),
         .sub_i  (s1_sub_q),
         .res_o  (r2[j])
      );
      assign c2[j+1]             = r2[j].c;
      assign s2_hi_d[32*j +: 32] = r2[j].s;
   end

   // Carry out of the top of the 256-bit word is discarded.
   assign unused_top_c = c2[4];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CRA_IDLE;
         target_q   <= '0;
         accepted_q <= '0;
         emitted_q  <= '0;
         done_q     <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_lo_q    <= '0;
         s1_c3_q    <= 1'b0;
         s1_w_q     <= W32;
         s1_a_hi_q  <= '0;
         s1_b_hi_q  <= '0;
         s1_sub_q   <= 1'b0;
         s2_vld_q   <= 1'b0;
         sum_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            CRA_IDLE: begin
               if (start_i) begin
                  target_q   <= cnt_target_i;
                  accepted_q <= '0;
                  emitted_q  <= '0;
                  if (cnt_target_i == '0) done_q  <= 1'b1;
                  else                    state_q <= CRA_RUN;
               end
            end
            CRA_RUN: begin
               if (in_fire) accepted_q <= accepted_q + 32'd1;
               if (out_fire) begin
                  emitted_q <= emitted_q + 32'd1;
                  if ((emitted_q + 32'd1) == target_q) begin
                     state_q <= CRA_IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= CRA_IDLE;
         endcase

         if (s1_take) begin
            s1_vld_q <= in_fire;
            if (in_fire) begin
               s1_lo_q   <= s1_lo_d;
               s1_c3_q   <= c1[4];
               s1_w_q    <= width_i;
               s1_a_hi_q <= a_i[255:128];
               s1_b_hi_q <= b_i[255:128];
               s1_sub_q  <= sub_in;
            end
         end

         if (s2_take) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) sum_q <= {s2_hi_d, s1_lo_q};
         end
      end
   end

   assign sum_o       = sum_q;
   assign out_valid_o = s2_vld_q;
   assign busy_o      = busy;
   assign done_o      = done_q;

endmodule
